// File: rtl/bbox_raster_scan_pkg.sv
// Shared definitions for the bounding-box raster scan stage: FSM states and
// screen-size constants.
package bbox_raster_scan_pkg;

  localparam int DEFAULT_SCREEN_W_LOG2 = 8;

  // Largest valid coordinate on a square screen of 2^l pixels per side
  function automatic int screen_max(input int l);
    return (1 << l) - 1;
  endfunction

  localparam int SCREEN_MAX = screen_max(DEFAULT_SCREEN_W_LOG2);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

endpackage

// File: rtl/bbox_raster_scan_if.sv
// Handshake bundles for the raster scan stage: bounding boxes in, pixels out.
interface bbox_if #(
  parameter int COORD_W = 16
);
  logic               valid;
  logic               ready;
  logic [COORD_W-1:0] x_min;
  logic [COORD_W-1:0] x_max;
  logic [COORD_W-1:0] y_min;
  logic [COORD_W-1:0] y_max;

  modport master (output valid, x_min, x_max, y_min, y_max, input ready);
  modport slave  (input valid, x_min, x_max, y_min, y_max, output ready);
endinterface

interface pix_if #(
  parameter int SCREEN_W_LOG2 = 8,
  parameter int ADDR_W        = 16
);
  logic                     valid;
  logic                     ready;
  logic [SCREEN_W_LOG2-1:0] x;
  logic [SCREEN_W_LOG2-1:0] y;
  logic [ADDR_W-1:0]        addr;
  logic                     last;

  modport master (output valid, x, y, addr, last, input ready);
  modport slave  (input valid, x, y, addr, last, output ready);
endinterface

// File: rtl/bbox_raster_scan_coord_step.sv
// Combinational row-major step: next pixel position and address inside the
// captured box, plus end-of-box flags.
module raster_coord_step #(
  parameter int SCREEN_W_LOG2 = 8,
  parameter int ADDR_W        = 16
) (
  input  logic [SCREEN_W_LOG2-1:0] x,
  input  logic [SCREEN_W_LOG2-1:0] y,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [SCREEN_W_LOG2-1:0] x_min,
  input  logic [SCREEN_W_LOG2-1:0] x_max,
  input  logic [SCREEN_W_LOG2-1:0] y_max,
  output logic [SCREEN_W_LOG2-1:0] x_next,
  output logic [SCREEN_W_LOG2-1:0] y_next,
  output logic [ADDR_W-1:0]        addr_next,
  output logic                     at_end,
  output logic                     next_last
);

  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(1) << SCREEN_W_LOG2;

  always_comb begin
    // NOTE: every output gets a default first so no path through the block
    // leaves it unassigned, which would otherwise infer a latch.
    x_next    = x;
    y_next    = y;
    addr_next = addr;
    at_end    = 1'b0;
    if (x < x_max) begin
      x_next    = x + 1'b1;
      addr_next = addr + 1'b1;
    end else if (y < y_max) begin
      // Wrap to the start of the next row without a multiply
      x_next    = x_min;
      y_next    = y + 1'b1;
      addr_next = addr + ROW_STRIDE - ADDR_W'(x_max - x_min);
    end else begin
      at_end = 1'b1;
    end
    next_last = (x_next == x_max) && (y_next == y_max);
  end

endmodule

// File: rtl/bbox_raster_scan.sv
// Captures a clamped bounding box and emits every pixel inside it in
// row-major order over a valid/ready stream, then pulses done.
module bbox_raster_scan
  import bbox_raster_scan_pkg::*;
#(
  parameter int SCREEN_W_LOG2 = DEFAULT_SCREEN_W_LOG2,
  parameter int COORD_W       = 16,
  parameter int ADDR_W        = 16
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  flush,
  bbox_if.slave box,
  pix_if.master pix,
  output logic  done
);

  typedef logic [SCREEN_W_LOG2-1:0] coord_t;

  localparam logic [COORD_W-1:0] MAX_COORD = COORD_W'(screen_max(SCREEN_W_LOG2));

  // Clamp first, then drop the upper bits
  function automatic coord_t clamp(input logic [COORD_W-1:0] v);
    return (v > MAX_COORD) ? '1 : v[SCREEN_W_LOG2-1:0];
  endfunction

  state_t state;
  coord_t x_min_r, x_max_r, y_max_r;
  coord_t cx_min, cx_max, cy_min, cy_max;
  coord_t x_next, y_next;
  logic [ADDR_W-1:0] addr_next;
  logic at_end, next_last;

  assign cx_min = clamp(box.x_min);
  assign cx_max = clamp(box.x_max);
  assign cy_min = clamp(box.y_min);
  assign cy_max = clamp(box.y_max);

  raster_coord_step #(
    .SCREEN_W_LOG2 (SCREEN_W_LOG2),
    .ADDR_W        (ADDR_W)
  ) u_step (
    .x         (pix.x),
    .y         (pix.y),
    .addr      (pix.addr),
    .x_min     (x_min_r),
    .x_max     (x_max_r),
    .y_max     (y_max_r),
    .x_next    (x_next),
    .y_next    (y_next),
    .addr_next (addr_next),
    .at_end    (at_end),
    .next_last (next_last)
  );

  // NOTE: state and outputs are registered with non-blocking assignments so
  // every right-hand side sees the pre-edge values regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      box.ready <= 1'b1;
      pix.valid <= 1'b0;
      pix.last  <= 1'b0;
      pix.x     <= '0;
      pix.y     <= '0;
      pix.addr  <= '0;
      done      <= 1'b0;
      x_min_r   <= '0;
      x_max_r   <= '0;
      y_max_r   <= '0;
    end else if (flush) begin
      state     <= IDLE;
      box.ready <= 1'b1;
      pix.valid <= 1'b0;
      pix.last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (box.valid && box.ready) begin
            x_min_r   <= cx_min;
            x_max_r   <= cx_max;
            y_max_r   <= cy_max;
            pix.x     <= cx_min;
            pix.y     <= cy_min;
            pix.addr  <= ADDR_W'({cy_min, cx_min});
            box.ready <= 1'b0;
            if ((cx_min > cx_max) || (cy_min > cy_max)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= SCAN;
              pix.valid <= 1'b1;
              pix.last  <= (cx_min == cx_max) && (cy_min == cy_max);
            end
          end
        end
        SCAN: begin
          if (pix.ready) begin
            if (at_end) begin
              state     <= DONE;
              pix.valid <= 1'b0;
              pix.last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              pix.x    <= x_next;
              pix.y    <= y_next;
              pix.addr <= addr_next;
              pix.last <= next_last;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          box.ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bbox_raster_scan.sv
// Randomized self-checking bench for bbox_raster_scan against a queue-based
// model of the expected pixel sequence.
module tb_bbox_raster_scan;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic done;

  bbox_if #(.COORD_W(16)) bx ();
  pix_if  #(.SCREEN_W_LOG2(8), .ADDR_W(16)) px ();

  bbox_raster_scan #(
    .SCREEN_W_LOG2 (8),
    .COORD_W       (16),
    .ADDR_W        (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .box   (bx),
    .pix   (px),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    bit last;
  } pix_t;

  pix_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic int clampc(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // Every pixel of the clamped box in row-major order
  task automatic build_expected(input int xmin, input int xmax, input int ymin, input int ymax);
    int x0, x1, y0, y1;
    pix_t p;
    x0 = clampc(xmin); x1 = clampc(xmax);
    y0 = clampc(ymin); y1 = clampc(ymax);
    exp_q.delete();
    for (int y = y0; y <= y1; y++) begin
      for (int x = x0; x <= x1; x++) begin
        p.x = x;
        p.y = y;
        p.last = (x == x1) && (y == y1);
        exp_q.push_back(p);
      end
    end
  endtask

  // Called at a falling edge with the DUT idle.
  task automatic run_box(input string name, input int xmin, input int xmax, input int ymin,
                         input int ymax, input int stall_pct, input int flush_after, input bit poke);
    int hs, cycles, budget;
    bit prev_stall, finished;
    logic [7:0] prev_x, prev_y;
    logic [15:0] prev_addr;
    logic prev_last;
    pix_t head;
    build_expected(xmin, xmax, ymin, ymax);
    budget = 20 * exp_q.size() + 50;
    checks++;
    if (bx.ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept_ready: got %b expected 1", name, bx.ready);
    end
    bx.valid = 1'b1;
    bx.x_min = 16'(xmin); bx.x_max = 16'(xmax);
    bx.y_min = 16'(ymin); bx.y_max = 16'(ymax);
    @(negedge clk);
    if (poke) begin
      bx.x_min = 16'd0; bx.x_max = 16'd255; bx.y_min = 16'd0; bx.y_max = 16'd255;
    end else begin
      bx.valid = 1'b0;
    end
    if (exp_q.size() == 0) begin
      checks++;
      if ({done, px.valid, bx.ready} !== 3'b100) begin
        errors++;
        $display("FAIL %s degen_done: got done/valid/ready=%b expected 100", name, {done, px.valid, bx.ready});
      end
      bx.valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({done, px.valid, bx.ready} !== 3'b001) begin
        errors++;
        $display("FAIL %s degen_idle: got done/valid/ready=%b expected 001", name, {done, px.valid, bx.ready});
      end
      return;
    end
    checks++;
    if (px.valid !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: got pix_valid=%b expected 1", name, px.valid);
    end
    hs = 0; cycles = 0; finished = 0; prev_stall = 0;
    prev_x = '0; prev_y = '0; prev_addr = '0; prev_last = 1'b0;
    while (!finished) begin
      px.ready = ($urandom_range(99) >= stall_pct);
      if (prev_stall) begin
        checks++;
        if ({px.valid, px.x, px.y, px.addr, px.last} !== {1'b1, prev_x, prev_y, prev_addr, prev_last}) begin
          errors++;
          $display("FAIL %s stall_hold: got v=%b (%0d,%0d) a=%h l=%b expected v=1 (%0d,%0d) a=%h l=%b",
                   name, px.valid, px.x, px.y, px.addr, px.last, prev_x, prev_y, prev_addr, prev_last);
        end
      end
      if (px.valid) begin
        checks++;
        if (px.addr !== {px.y, px.x} || done !== 1'b0) begin
          errors++;
          $display("FAIL %s addr_map: got addr=%h done=%b expected addr=%h done=0",
                   name, px.addr, done, {px.y, px.x});
        end
      end
      if (px.valid && px.ready) begin
        hs++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra_pixel: got (%0d,%0d) expected no more pixels", name, px.x, px.y);
          finished = 1;
        end else begin
          head = exp_q.pop_front();
          if ({px.x, px.y, px.addr, px.last} !== {8'(head.x), 8'(head.y), 16'(head.y * 256 + head.x), head.last}) begin
            errors++;
            $display("FAIL %s pixel%0d: got (%0d,%0d) a=%h l=%b expected (%0d,%0d) a=%h l=%b", name, hs,
                     px.x, px.y, px.addr, px.last, head.x, head.y, head.y * 256 + head.x, head.last);
          end
          if (hs == flush_after) begin
            @(negedge clk);
            flush = 1'b1;
            px.ready = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            checks++;
            if ({done, px.valid, bx.ready} !== 3'b001) begin
              errors++;
              $display("FAIL %s flush: got done/valid/ready=%b expected 001", name, {done, px.valid, bx.ready});
            end
            finished = 1;
          end else if (head.last) begin
            bx.valid = 1'b0;
            @(negedge clk);
            checks++;
            if ({done, px.valid, bx.ready} !== 3'b100) begin
              errors++;
              $display("FAIL %s done_pulse: got done/valid/ready=%b expected 100", name, {done, px.valid, bx.ready});
            end
            @(negedge clk);
            checks++;
            if ({done, px.valid, bx.ready} !== 3'b001) begin
              errors++;
              $display("FAIL %s back_idle: got done/valid/ready=%b expected 001", name, {done, px.valid, bx.ready});
            end
            finished = 1;
          end
        end
      end
      prev_stall = px.valid && !px.ready;
      prev_x = px.x; prev_y = px.y; prev_addr = px.addr; prev_last = px.last;
      if (!finished) begin
        @(negedge clk);
        cycles++;
        if (cycles > budget) begin
          checks++;
          errors++;
          $display("FAIL %s timeout: got %0d handshakes expected %0d more", name, hs, exp_q.size());
          finished = 1;
        end
      end
    end
    bx.valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({bx.ready, px.valid, px.last, done, px.x, px.y, px.addr} !== {4'b1000, 8'd0, 8'd0, 16'd0}) begin
      errors++;
      $display("FAIL reset: got rdy/v/l/done=%b x=%0d y=%0d a=%h expected 1000 0 0 0000",
               {bx.ready, px.valid, px.last, done}, px.x, px.y, px.addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_box("basic", 2, 4, 10, 11, 0, -1, 1'b0);
    run_box("single", 7, 7, 7, 7, 0, -1, 1'b0);
    run_box("degenerate", 5, 3, 0, 0, 0, -1, 1'b0);
  endtask

  task automatic test_stalls();
    run_box("stalls", 0, 3, 0, 3, 45, -1, 1'b0);
  endtask

  task automatic test_clamp();
    run_box("clamp", 254, 300, 254, 16'h1000, 0, -1, 1'b0);
  endtask

  task automatic test_flush();
    run_box("flush", 0, 3, 0, 3, 0, 3, 1'b0);
    run_box("after_flush", 0, 0, 0, 0, 0, -1, 1'b0);
  endtask

  task automatic test_ignore_busy();
    run_box("ignore_busy", 1, 2, 1, 2, 20, -1, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_box("b2b_a", 100, 102, 50, 50, 0, -1, 1'b0);
    run_box("b2b_b", 10, 11, 200, 201, 0, -1, 1'b0);
  endtask

  task automatic test_reset_mid();
    bx.valid = 1'b1;
    bx.x_min = 16'd0; bx.x_max = 16'd15; bx.y_min = 16'd0; bx.y_max = 16'd15;
    px.ready = 1'b1;
    @(negedge clk);
    bx.valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bx.ready, px.valid, px.last, done, px.x, px.y, px.addr} !== {4'b1000, 8'd0, 8'd0, 16'd0}) begin
      errors++;
      $display("FAIL reset_mid: got rdy/v/l/done=%b x=%0d y=%0d a=%h expected 1000 0 0 0000",
               {bx.ready, px.valid, px.last, done}, px.x, px.y, px.addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    int xmin, ymin, w, h;
    for (int i = 0; i < 10; i++) begin
      xmin = $urandom_range(0, 265);
      ymin = $urandom_range(0, 265);
      w = int'($urandom_range(0, 5)) - 1;
      h = int'($urandom_range(0, 4)) - 1;
      run_box("random", xmin, (xmin + w < 0) ? 0 : xmin + w, ymin, (ymin + h < 0) ? 0 : ymin + h,
              30, -1, 1'b0);
    end
  endtask

  initial begin
    bx.valid = 1'b0;
    bx.x_min = '0; bx.x_max = '0; bx.y_min = '0; bx.y_max = '0;
    px.ready = 1'b0;
    test_reset();
    test_basic();
    test_stalls();
    test_clamp();
    test_flush();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
